// File: rtl/btn_event_encoder_if.sv
// Button/event bundle between the button front end and its consumer (the Simon FSM).
// The slave modport is the encoder side and the master modport is the consumer side.
interface btn_event_encoder_if;
  logic [3:0] btn;
  logic       ev_ack;
  logic       ev_valid;
  logic [1:0] ev_val;
  logic [3:0] btn_level;
  logic       overrun;
  logic [7:0] drop_cnt;

  modport slave (
    input  btn,
    input  ev_ack,
    output ev_valid,
    output ev_val,
    output btn_level,
    output overrun,
    output drop_cnt
  );

  modport master (
    output btn,
    output ev_ack,
    input  ev_valid,
    input  ev_val,
    input  btn_level,
    input  overrun,
    input  drop_cnt
  );
endinterface

// File: rtl/btn_event_encoder.sv
// Synchronises, debounces and priority-encodes four push-buttons into a single-entry
// press event with a valid/ack handshake, and counts presses that had to be dropped.
module btn_event_encoder #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic                 clk,
  input  logic                 reset,
  btn_event_encoder_if.slave   bus
);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0] s1_reg, s2_reg;
  logic [3:0] level_reg, level_next, level_prev_reg;
  logic [3:0] press;
  logic [1:0] win_idx;
  logic [2:0] n_press, drop_add;
  logic [8:0] drop_sum;

  logic       valid_reg, valid_next;
  logic [1:0] val_reg, val_next;
  logic       overrun_reg, overrun_next;
  logic [7:0] drop_cnt_reg, drop_cnt_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_reg         <= '0;
      s2_reg         <= '0;
      level_reg      <= '0;
      level_prev_reg <= '0;
    end else begin
      s1_reg         <= bus.btn;
      s2_reg         <= s1_reg;
      level_reg      <= level_next;
      level_prev_reg <= level_reg;
    end
  end

  // Per-button debounce: a count restarts whenever the synchronised level agrees again.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_debounce
      logic [CNT_W-1:0] cnt_reg;
      logic             accept;

      assign accept         = (s2_reg[gi] != level_reg[gi]) && (cnt_reg == CNT_MAX);
      assign level_next[gi] = accept ? s2_reg[gi] : level_reg[gi];

      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_reg <= '0;
        end else if (s2_reg[gi] == level_reg[gi] || accept) begin
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end
  endgenerate

  assign press = level_reg & ~level_prev_reg;

  // Lowest index wins; every other simultaneous press is a drop.
  always_comb begin
    win_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (press[i]) win_idx = 2'(i);
    end
    n_press = {2'b00, press[0]} + {2'b00, press[1]} + {2'b00, press[2]} + {2'b00, press[3]};
  end

  always_comb begin
    valid_next = valid_reg;
    val_next   = val_reg;
    drop_add   = 3'd0;
    if (|press) begin
      if (!valid_reg || bus.ev_ack) begin
        valid_next = 1'b1;
        val_next   = win_idx;
        drop_add   = n_press - 3'd1;
      end else begin
        drop_add   = n_press;
      end
    end else if (bus.ev_ack) begin
      valid_next = 1'b0;
    end
    drop_sum      = {1'b0, drop_cnt_reg} + {6'b0, drop_add};
    drop_cnt_next = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    overrun_next  = overrun_reg | (drop_add != 3'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg    <= 1'b0;
      val_reg      <= 2'd0;
      overrun_reg  <= 1'b0;
      drop_cnt_reg <= 8'd0;
    end else begin
      valid_reg    <= valid_next;
      val_reg      <= val_next;
      overrun_reg  <= overrun_next;
      drop_cnt_reg <= drop_cnt_next;
    end
  end

  assign bus.ev_valid  = valid_reg;
  assign bus.ev_val    = val_reg;
  assign bus.btn_level = level_reg;
  assign bus.overrun   = overrun_reg;
  assign bus.drop_cnt  = drop_cnt_reg;
endmodule

// File: tb/tb_btn_event_encoder.sv
// Directed bench for btn_event_encoder with a short debounce window; expected values
// are hand-derived from the press/debounce timing (btn_level at k+5, ev_valid at k+6).
module tb_btn_event_encoder;
  localparam int DB = 4;

  logic clk = 1'b0;
  logic reset;
  int   tests_run = 0;
  int   tests_failed = 0;

  btn_event_encoder_if bus_if ();

  btn_event_encoder #(.DEBOUNCE_CYCLES(DB), .CNT_W(20)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: %0d", tag, got);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ack_pulse();
    bus_if.ev_ack = 1'b1;
    cyc();
    bus_if.ev_ack = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) cyc();
    reset = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    bus_if.btn    = 4'b0000;
    bus_if.ev_ack = 1'b0;

    // 1: reset state and single press latency
    repeat (2) cyc();
    chk("rst_valid", 32'(bus_if.ev_valid), 0);
    chk("rst_level", 32'(bus_if.btn_level), 0);
    chk("rst_drop", 32'(bus_if.drop_cnt), 0);
    reset = 1'b0;
    bus_if.btn = 4'b0001;
    repeat (5) cyc();
    chk("t1_level_k4", 32'(bus_if.btn_level), 0);
    cyc();
    chk("t1_level_k5", 32'(bus_if.btn_level), 1);
    chk("t1_valid_k5", 32'(bus_if.ev_valid), 0);
    cyc();
    chk("t1_valid_k6", 32'(bus_if.ev_valid), 1);
    chk("t1_val", 32'(bus_if.ev_val), 0);
    repeat (3) cyc();
    chk("t1_valid_hold", 32'(bus_if.ev_valid), 1);
    chk("t1_overrun", 32'(bus_if.overrun), 0);
    bus_if.btn = 4'b0000;
    ack_pulse();
    chk("t1_ack_clr", 32'(bus_if.ev_valid), 0);
    repeat (8) cyc();
    chk("t1_release", 32'(bus_if.btn_level), 0);

    // 2: bounce on button 2 must not produce an event
    for (int r = 0; r < 2; r++) begin
      bus_if.btn = 4'b0100;
      repeat (2) cyc();
      bus_if.btn = 4'b0000;
      repeat (2) cyc();
      chk("t2_bounce_valid", 32'(bus_if.ev_valid), 0);
      chk("t2_bounce_level", 32'(bus_if.btn_level), 0);
    end
    bus_if.btn = 4'b0100;
    repeat (6) cyc();
    chk("t2_valid_k5", 32'(bus_if.ev_valid), 0);
    cyc();
    chk("t2_valid_k6", 32'(bus_if.ev_valid), 1);
    chk("t2_val", 32'(bus_if.ev_val), 2);
    bus_if.btn = 4'b0000;
    ack_pulse();
    repeat (8) cyc();

    // 3: simultaneous presses, then re-press of button 1 only after debounced release
    bus_if.btn = 4'b1010;
    repeat (7) cyc();
    chk("t3_valid", 32'(bus_if.ev_valid), 1);
    chk("t3_val", 32'(bus_if.ev_val), 1);
    chk("t3_drop", 32'(bus_if.drop_cnt), 1);
    chk("t3_overrun", 32'(bus_if.overrun), 1);
    ack_pulse();
    bus_if.btn = 4'b1000;
    repeat (2) cyc();
    bus_if.btn = 4'b1010;
    repeat (8) cyc();
    chk("t3_glitch_noev", 32'(bus_if.ev_valid), 0);
    bus_if.btn = 4'b1000;
    repeat (6) cyc();
    chk("t3_rel_level", 32'(bus_if.btn_level), 4'b1000);
    bus_if.btn = 4'b1010;
    repeat (6) cyc();
    chk("t3_repress_k5", 32'(bus_if.ev_valid), 0);
    cyc();
    chk("t3_repress_valid", 32'(bus_if.ev_valid), 1);
    chk("t3_repress_val", 32'(bus_if.ev_val), 1);
    chk("t3_drop_same", 32'(bus_if.drop_cnt), 1);
    bus_if.btn = 4'b0000;
    ack_pulse();
    repeat (8) cyc();

    // 4: drop while held, then ack coinciding with a new press
    do_reset();
    bus_if.btn = 4'b0001;
    repeat (7) cyc();
    chk("t4_val0", 32'(bus_if.ev_val), 0);
    bus_if.btn = 4'b1001;
    repeat (8) cyc();
    chk("t4_held_val", 32'(bus_if.ev_val), 0);
    chk("t4_drop1", 32'(bus_if.drop_cnt), 1);
    bus_if.btn = 4'b1101;
    repeat (6) cyc();
    bus_if.ev_ack = 1'b1;
    cyc();
    bus_if.ev_ack = 1'b0;
    chk("t4_ackpress_valid", 32'(bus_if.ev_valid), 1);
    chk("t4_ackpress_val", 32'(bus_if.ev_val), 2);
    chk("t4_ackpress_drop", 32'(bus_if.drop_cnt), 1);
    bus_if.btn = 4'b0000;
    ack_pulse();
    repeat (8) cyc();

    // 5: drop counter saturation, then ack with nothing held
    do_reset();
    for (int r = 1; r <= 80; r++) begin
      bus_if.btn = 4'b1111;
      repeat (7) cyc();
      bus_if.btn = 4'b0000;
      repeat (7) cyc();
      if (r == 1) chk("t5_drop_r1", 32'(bus_if.drop_cnt), 3);
      if (r == 63) chk("t5_drop_r63", 32'(bus_if.drop_cnt), 251);
      if (r == 64) chk("t5_drop_r64", 32'(bus_if.drop_cnt), 255);
      if (r == 65) chk("t5_drop_r65", 32'(bus_if.drop_cnt), 255);
    end
    chk("t5_drop_end", 32'(bus_if.drop_cnt), 255);
    chk("t5_held_val", 32'(bus_if.ev_val), 0);
    ack_pulse();
    chk("t5_ack_clr", 32'(bus_if.ev_valid), 0);
    ack_pulse();
    chk("t5_ack_idle_valid", 32'(bus_if.ev_valid), 0);
    chk("t5_ack_idle_val", 32'(bus_if.ev_val), 0);
    chk("t5_ack_idle_drop", 32'(bus_if.drop_cnt), 255);
    chk("t5_overrun", 32'(bus_if.overrun), 1);

    // 6: reset with event held and button 1 mid-debounce
    bus_if.btn = 4'b0001;
    repeat (7) cyc();
    chk("t6_pre_valid", 32'(bus_if.ev_valid), 1);
    bus_if.btn = 4'b0011;
    repeat (3) cyc();
    reset = 1'b1;
    cyc();
    chk("t6_rst_valid", 32'(bus_if.ev_valid), 0);
    chk("t6_rst_level", 32'(bus_if.btn_level), 0);
    chk("t6_rst_overrun", 32'(bus_if.overrun), 0);
    chk("t6_rst_drop", 32'(bus_if.drop_cnt), 0);
    bus_if.btn = 4'b0010;
    cyc();
    reset = 1'b0;
    repeat (6) cyc();
    chk("t6_level_k5", 32'(bus_if.btn_level), 4'b0010);
    chk("t6_valid_k5", 32'(bus_if.ev_valid), 0);
    cyc();
    chk("t6_valid_k6", 32'(bus_if.ev_valid), 1);
    chk("t6_val", 32'(bus_if.ev_val), 1);
    chk("t6_drop", 32'(bus_if.drop_cnt), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/btn_event_encoder.md
Name: btn_event_encoder

Overview:
Front-end input stage that sits directly upstream of the Simon FSM and replaces the slow-tick button sampler.
- Synchronises and debounces the four push-buttons on the 100 MHz clock.
- Detects presses and priority-encodes them into a 2-bit button code.
- Holds each press in a single-entry event register with a valid/ack handshake, so a press is never lost between slow FSM ticks.
- Reports dropped presses for the debug display.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive clk cycles a synchronised level must differ from the debounced level before it is accepted (10 ms at 100 MHz); legal range 2 to 2^CNT_W-1.
CNT_W, 20, width of each per-button debounce counter.

Ports:
clk  input  1  100 MHz system clock; all state updates on its rising edge.
reset  input  1  synchronous, active-high reset.
btn  input  4  raw buttons, active-high: bit0 BTNU, bit1 BTNL, bit2 BTNR, bit3 BTND.
ev_ack  input  1  consumer pulse; consumes the held event.
ev_valid  output  1  a press event is held.
ev_val  output  2  code of the held press (0..3 = button index).
btn_level  output  4  debounced button levels.
overrun  output  1  sticky; set when any press is dropped.
drop_cnt  output  8  saturating count of dropped presses.

Behaviour:
- Reset (synchronous, checked every edge, overrides everything): synchroniser flops, debounced levels, counters, ev_valid, ev_val, overrun and drop_cnt all go to 0. Reset mid-debounce or with an event held discards the in-progress state. After reset, a button still held is treated as a new press once it has been debounced.
- Synchroniser: two flops per bit (s1 <= btn, s2 <= s1). No logic between them.
- Debounce, per bit i, each edge:
  - If s2[i] == btn_level[i]: cnt[i] <= 0.
  - Else if cnt[i] == DEBOUNCE_CYCLES-1: btn_level[i] <= s2[i] and cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i]+1.
  - Any bounce back to the debounced level restarts the count. Press and release are debounced identically.
- Press detect: press[i] = btn_level[i] rising, a one-cycle internal strobe (registered previous level).
  - A held button yields exactly one press.
  - A second press of the same button requires a debounced release first.
- Encoder, same-cycle presses: the lowest index wins. Each other set bit counts as one drop.
- Event register, on an edge where the winning press is present:
  - If ev_valid==0, or ev_valid==1 with ev_ack==1 on the same edge: load ev_val, set ev_valid=1. Simultaneous ack and new press means the old event is consumed and the new one loaded, with no gap and no drop.
  - If ev_valid==1 and ev_ack==0: the new press is dropped and the held event is unchanged.
- No press on the edge:
  - ev_ack==1 clears ev_valid.
  - ev_ack while ev_valid==0 is ignored.
  - ev_val holds its last value when ev_valid==0.
- Drops:
  - Every dropped press sets overrun=1; it is cleared only by reset.
  - drop_cnt adds the number of presses dropped that edge (0..4) and saturates at 255.
- Latency: with the first sampling edge of btn high called edge k, btn_level rises at edge k+1+DEBOUNCE_CYCLES and ev_valid rises at edge k+2+DEBOUNCE_CYCLES.
- ev_ack is a one-cycle clk pulse; the consumer generates it at most once per accepted event.

Test Plan:
1. DEBOUNCE_CYCLES=4: reset, then btn=0001 held from edge k -> btn_level[0]=1 at k+5, ev_valid=1/ev_val=0 at k+6, stays high with no ack; overrun=0.
2. DEBOUNCE_CYCLES=4: btn[2] toggles 1,0,1,0 every 2 cycles, then holds 1 -> no event during the bounce; exactly one event, ev_val=2, 6 edges after the final rise is first sampled.
3. btn=1010 rising together -> ev_val=1; drop_cnt=1; overrun=1; the held release and re-press of button 1 produce a new event only after the release is debounced.
4. Event held for button 0, no ack; press button 3 -> ev_val stays 0, drop_cnt increments to 1. Then ack on the same edge as a button 2 press -> ev_valid stays 1, ev_val=2, drop_cnt unchanged.
5. Force 300 drops -> drop_cnt saturates at 255. ev_ack with ev_valid=0 -> no change.
6. Assert reset with an event held and button 1 mid-debounce -> all outputs 0 next edge. Release reset with button 1 still held -> new event ev_val=1 after a full debounce.
